trap_ctrl: RTL and testbench

// - Sequences architectural traps and MRET reported by the misc exec unit (ex_valid / ret_valid).
// - Accepts one trap/return request at a time and pulses a pipeline flush.
// - Waits for in-flight work to drain, updates mepc/mcause (and mtval), then issues a PC redirect.
// - Owns the M-mode trap CSRs and serves their reads and writes.

---
 rtl/trap_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// ----------------------------------------------------------------------------
// trap_ctrl
// Sequences architectural traps and MRET requests coming from the misc exec
// unit. One request is taken at a time: it is accepted in IDLE, a one-cycle
// flush pulse kills younger work, the controller waits in DRAIN until the
// backend has no older uncommitted work, updates the trap CSRs (traps only)
// and then holds a fetch redirect in REDIRECT until fetch takes it.
//
// The block also owns the M-mode trap CSRs (mtvec, mepc, mcause, mtval) and
// serves their reads (combinational on csr_addr) and writes (any state).
//
// Optional feature macro: TRAP_MTVAL_EN
//   defined   : adds input req_tval and the mtval register; traps load mtval.
//   undefined : no req_tval port, no mtval storage; 0x343 reads 0.
// ----------------------------------------------------------------------------
module trap_ctrl #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,

    // trap / return request
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_is_ret,
    input  logic [4:0]      req_cause,
    input  logic [XLEN-1:0] req_pc,
`ifdef TRAP_MTVAL_EN
    input  logic [XLEN-1:0] req_tval,
`endif

    // backend drain status and pipeline kill
    input  logic            inflight_empty,
    output logic            flush,

    // fetch redirect
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_target,
    input  logic            redirect_ready,

    // CSR access
    input  logic            csr_we,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DRAIN    = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

    localparam logic [11:0] CSR_MTVEC  = 12'h305;
    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam logic [11:0] CSR_MTVAL  = 12'h343;

    // ------------------------------------------------------------------------
    // Helper functions for the CSR field masks
    // ------------------------------------------------------------------------

    // Force the two low bits to zero (word-aligned PC / direct-mode vector).
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] value);
        return {value[XLEN-1:2], 2'b00};
    endfunction

    // Interrupt flag in mcause is never set by this block, so it reads 0.
    function automatic logic [XLEN-1:0] clear_msb(input logic [XLEN-1:0] value);
        return {1'b0, value[XLEN-2:0]};
    endfunction

    // Zero-extend the 5-bit exception code into an mcause value.
    function automatic logic [XLEN-1:0] cause_word(input logic [4:0] code);
        return {{(XLEN-5){1'b0}}, code};
    endfunction

    // ------------------------------------------------------------------------
    // State and storage
    // ------------------------------------------------------------------------
    logic [1:0]      state_r;
    logic [1:0]      state_nxt_s;

    logic            lat_is_ret_r;
    logic [4:0]      lat_cause_r;
    logic [XLEN-1:0] lat_pc_r;
`ifdef TRAP_MTVAL_EN
    logic [XLEN-1:0] lat_tval_r;
    logic [XLEN-1:0] mtval_r;
`endif

    logic            flush_r;
    logic            redirect_valid_r;
    logic [XLEN-1:0] redirect_target_r;

    logic [XLEN-1:0] mtvec_r;
    logic [XLEN-1:0] mepc_r;
    logic [XLEN-1:0] mcause_r;

    // ------------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------------
    logic accept_s;
    logic drain_exit_s;
    logic trap_exit_s;
    logic redirect_done_s;

    logic wr_mtvec_s;
    logic wr_mepc_s;
    logic wr_mcause_s;
`ifdef TRAP_MTVAL_EN
    logic wr_mtval_s;
`endif

    // Handshake and transition strobes derived from the current state.
    always_comb begin
        accept_s        = req_valid && (state_r == ST_IDLE);
        drain_exit_s    = (state_r == ST_DRAIN) && inflight_empty;
        trap_exit_s     = drain_exit_s && !lat_is_ret_r;
        redirect_done_s = (state_r == ST_REDIRECT) && redirect_ready;
    end

    // CSR write strobes; writes to unmapped addresses fall through unused.
    always_comb begin
        wr_mtvec_s  = csr_we && (csr_addr == CSR_MTVEC);
        wr_mepc_s   = csr_we && (csr_addr == CSR_MEPC);
        wr_mcause_s = csr_we && (csr_addr == CSR_MCAUSE);
`ifdef TRAP_MTVAL_EN
        wr_mtval_s  = csr_we && (csr_addr == CSR_MTVAL);
`endif
    end

    // Next-state selection for the IDLE -> DRAIN -> REDIRECT sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (inflight_empty) begin
                    state_nxt_s = ST_REDIRECT;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_REDIRECT: begin
                if (redirect_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_REDIRECT;
                end
            end
            default: begin
                // Unreachable encoding: recover to a quiet idle.
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequencer registers
    // ------------------------------------------------------------------------

    // FSM state, flush pulse and redirect outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r           <= ST_IDLE;
            flush_r           <= 1'b0;
            redirect_valid_r  <= 1'b0;
            redirect_target_r <= {XLEN{1'b0}};
        end else begin
            state_r          <= state_nxt_s;
            flush_r          <= accept_s;
            redirect_valid_r <= (state_nxt_s == ST_REDIRECT);
            if (drain_exit_s) begin
                // The vector/return address seen here is the pre-edge value,
                // so a same-cycle CSR write does not steer this redirect.
                if (lat_is_ret_r) begin
                    redirect_target_r <= mepc_r;
                end else begin
                    redirect_target_r <= mtvec_r;
                end
            end else begin
                redirect_target_r <= redirect_target_r;
            end
        end
    end

    // Capture the accepted request so the request bus is free afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_is_ret_r <= 1'b0;
            lat_cause_r  <= 5'd0;
            lat_pc_r     <= {XLEN{1'b0}};
`ifdef TRAP_MTVAL_EN
            lat_tval_r   <= {XLEN{1'b0}};
`endif
        end else if (accept_s) begin
            lat_is_ret_r <= req_is_ret;
            lat_cause_r  <= req_cause;
            lat_pc_r     <= req_pc;
`ifdef TRAP_MTVAL_EN
            lat_tval_r   <= req_tval;
`endif
        end else begin
            lat_is_ret_r <= lat_is_ret_r;
            lat_cause_r  <= lat_cause_r;
            lat_pc_r     <= lat_pc_r;
`ifdef TRAP_MTVAL_EN
            lat_tval_r   <= lat_tval_r;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Trap CSRs
    // ------------------------------------------------------------------------

    // mtvec: software-written only, direct mode so the low bits stay zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtvec_r <= align_word(MTVEC_RESET);
        end else if (wr_mtvec_s) begin
            mtvec_r <= align_word(csr_wdata);
        end else begin
            mtvec_r <= mtvec_r;
        end
    end

    // mepc: trap update has priority over a coincident software write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mepc_r <= {XLEN{1'b0}};
        end else if (trap_exit_s) begin
            mepc_r <= align_word(lat_pc_r);
        end else if (wr_mepc_s) begin
            mepc_r <= align_word(csr_wdata);
        end else begin
            mepc_r <= mepc_r;
        end
    end

    // mcause: trap update has priority; the interrupt bit is read-only zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcause_r <= {XLEN{1'b0}};
        end else if (trap_exit_s) begin
            mcause_r <= cause_word(lat_cause_r);
        end else if (wr_mcause_s) begin
            mcause_r <= clear_msb(csr_wdata);
        end else begin
            mcause_r <= mcause_r;
        end
    end

`ifdef TRAP_MTVAL_EN
    // mtval: loaded with the faulting value on a trap; MRET leaves it alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtval_r <= {XLEN{1'b0}};
        end else if (trap_exit_s) begin
            mtval_r <= lat_tval_r;
        end else if (wr_mtval_s) begin
            mtval_r <= csr_wdata;
        end else begin
            mtval_r <= mtval_r;
        end
    end
`endif

    // CSR read mux; unmapped addresses read as zero.
    always_comb begin
        csr_rdata = {XLEN{1'b0}};
        case (csr_addr)
            CSR_MTVEC:  csr_rdata = mtvec_r;
            CSR_MEPC:   csr_rdata = mepc_r;
            CSR_MCAUSE: csr_rdata = mcause_r;
`ifdef TRAP_MTVAL_EN
            CSR_MTVAL:  csr_rdata = mtval_r;
`else
            CSR_MTVAL:  csr_rdata = {XLEN{1'b0}};
`endif
            default:    csr_rdata = {XLEN{1'b0}};
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------

    // Drive ports from the registered state.
    always_comb begin
        req_ready       = (state_r == ST_IDLE);
        flush           = flush_r;
        redirect_valid  = redirect_valid_r;
        redirect_target = redirect_target_r;
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// ----------------------------------------------------------------------------
// tb_trap_ctrl
// Self-checking bench for trap_ctrl. A transaction-level reference model
// (busy / drained / redirect-pending flags plus CSR values) is advanced on
// every rising edge from the stimulus the bench drove, and every falling
// edge compares all DUT outputs against it. Directed scenarios add literal
// expectations, followed by a randomized soak.
// ----------------------------------------------------------------------------
module tb_trap_ctrl;

    localparam logic [31:0] TB_MTVEC_RESET = 32'h0000_1003;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_ret;
    logic [4:0]  req_cause;
    logic [31:0] req_pc;
`ifdef TRAP_MTVAL_EN
    logic [31:0] req_tval;
`endif
    logic        inflight_empty;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        redirect_ready;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;

    trap_ctrl #(
        .XLEN        (32),
        .MTVEC_RESET (TB_MTVEC_RESET)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_is_ret      (req_is_ret),
        .req_cause       (req_cause),
        .req_pc          (req_pc),
`ifdef TRAP_MTVAL_EN
        .req_tval        (req_tval),
`endif
        .inflight_empty  (inflight_empty),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .redirect_ready  (redirect_ready),
        .csr_we          (csr_we),
        .csr_addr        (csr_addr),
        .csr_wdata       (csr_wdata),
        .csr_rdata       (csr_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    bit          m_busy;      // a request is in progress
    bit          m_drained;   // drain finished, redirect pending/held
    bit          m_redir;     // redirect_valid expected high
    bit          m_flush;
    bit          m_ret;
    logic [4:0]  m_cause;
    logic [31:0] m_pc;
    logic [31:0] m_tval;
    logic [31:0] m_target;
    logic [31:0] m_mtvec;
    logic [31:0] m_mepc;
    logic [31:0] m_mcause;
    logic [31:0] m_mtval;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_drained = 1'b0; m_redir = 1'b0; m_flush = 1'b0;
        m_ret = 1'b0; m_cause = 5'd0; m_pc = 32'd0; m_tval = 32'd0;
        m_target = 32'd0;
        m_mtvec  = TB_MTVEC_RESET & 32'hFFFF_FFFC;
        m_mepc   = 32'd0;
        m_mcause = 32'd0;
        m_mtval  = 32'd0;
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] addr);
        case (addr)
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
`ifdef TRAP_MTVAL_EN
            12'h343: return m_mtval;
`endif
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model by one rising edge using the inputs the bench drove.
    task automatic model_step();
        bit acc;
        bit ex;
        bit done;
        logic [31:0] old_mtvec;
        logic [31:0] old_mepc;
        old_mtvec = m_mtvec;
        old_mepc  = m_mepc;
        acc  = req_valid && !m_busy;
        ex   = m_busy && !m_drained && inflight_empty;
        done = m_redir && redirect_ready;
        if (csr_we) begin
            case (csr_addr)
                12'h305: m_mtvec  = csr_wdata & 32'hFFFF_FFFC;
                12'h341: m_mepc   = csr_wdata & 32'hFFFF_FFFC;
                12'h342: m_mcause = csr_wdata & 32'h7FFF_FFFF;
`ifdef TRAP_MTVAL_EN
                12'h343: m_mtval  = csr_wdata;
`endif
                default: ;
            endcase
        end
        if (ex) begin
            m_drained = 1'b1;
            m_redir   = 1'b1;
            if (m_ret) begin
                m_target = old_mepc;
            end else begin
                m_target = old_mtvec;
                m_mepc   = m_pc & 32'hFFFF_FFFC;
                m_mcause = {27'd0, m_cause};
`ifdef TRAP_MTVAL_EN
                m_mtval  = m_tval;
`endif
            end
        end
        if (done) begin
            m_busy  = 1'b0;
            m_redir = 1'b0;
        end
        m_flush = acc;
        if (acc) begin
            m_busy    = 1'b1;
            m_drained = 1'b0;
            m_ret     = req_is_ret;
            m_cause   = req_cause;
            m_pc      = req_pc;
`ifdef TRAP_MTVAL_EN
            m_tval    = req_tval;
`endif
        end
    endtask

    // Compare every DUT output against the model.
    task automatic check_model();
        chk("flush", {31'd0, flush}, {31'd0, m_flush});
        chk("req_ready", {31'd0, req_ready}, {31'd0, !m_busy});
        chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_redir});
        if (m_redir) chk("redirect_target", redirect_target, m_target);
        chk("csr_rdata", csr_rdata, model_read(csr_addr));
    endtask

    // One clock: model on the rising edge, compare on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0; req_is_ret = 1'b0; req_cause = 5'd0; req_pc = 32'd0;
`ifdef TRAP_MTVAL_EN
        req_tval = 32'd0;
`endif
        inflight_empty = 1'b1; redirect_ready = 1'b1;
        csr_we = 1'b0; csr_addr = 12'h305; csr_wdata = 32'd0;
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
        csr_we = 1'b1; csr_addr = addr; csr_wdata = data;
        cycle();
        csr_we = 1'b0;
    endtask

    task automatic send_req(input bit is_ret, input logic [4:0] cause, input logic [31:0] pc);
        req_valid = 1'b1; req_is_ret = is_ret; req_cause = cause; req_pc = pc;
`ifdef TRAP_MTVAL_EN
        req_tval = pc ^ 32'h5A5A_0000;
`endif
        cycle();
        req_valid = 1'b0;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        // reset state
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst_target", redirect_target, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mtvec", csr_rdata, 32'h0000_1000);
        @(negedge clk);

        // ECALL
        csr_write(12'h305, 32'h0000_0100);
        redirect_ready = 1'b0;
        send_req(1'b0, 5'd11, 32'h0000_0080);
        chk("ecall_flush", {31'd0, flush}, 32'd1);
        chk("ecall_ready_low", {31'd0, req_ready}, 32'd0);
        csr_addr = 12'h341;
        cycle();
        chk("ecall_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        chk("ecall_target", redirect_target, 32'h0000_0100);
        chk("ecall_flush_gone", {31'd0, flush}, 32'd0);
        chk("ecall_mepc", csr_rdata, 32'h0000_0080);
        csr_addr = 12'h342;
        redirect_ready = 1'b1;
        cycle();
        chk("ecall_mcause", csr_rdata, 32'd11);
        chk("ecall_idle", {31'd0, req_ready}, 32'd1);

        // Drain stall
        inflight_empty = 1'b0;
        send_req(1'b0, 5'd2, 32'h0000_0302);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_no_redirect", {31'd0, redirect_valid}, 32'd0);
        end
        inflight_empty = 1'b1;
        csr_addr = 12'h341;
        cycle();
        chk("stall_redirect", {31'd0, redirect_valid}, 32'd1);
        chk("stall_mepc", csr_rdata, 32'h0000_0300);
        cycle();

        // MRET
        csr_write(12'h341, 32'h0000_0204);
        send_req(1'b1, 5'd7, 32'h0000_0900);
        csr_addr = 12'h342;
        cycle();
        chk("mret_target", redirect_target, 32'h0000_0204);
        chk("mret_mcause", csr_rdata, 32'd2);
        csr_addr = 12'h341;
        cycle();
        chk("mret_mepc", csr_rdata, 32'h0000_0204);

        // Backpressure (a pending request must not be taken early)
        redirect_ready = 1'b0;
        send_req(1'b0, 5'd3, 32'h0000_0400);
        cycle();
        req_valid = 1'b1; req_cause = 5'd9; req_pc = 32'h0000_0500;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_valid", {31'd0, redirect_valid}, 32'd1);
            chk("bp_target", redirect_target, 32'h0000_0100);
            chk("bp_ready_low", {31'd0, req_ready}, 32'd0);
        end
        req_valid = 1'b0;
        redirect_ready = 1'b1;
        cycle();
        chk("bp_idle", {31'd0, req_ready}, 32'd1);

        // CSR masking
        csr_write(12'h305, 32'h0000_0103);
        chk("mask_mtvec", csr_rdata, 32'h0000_0100);
        csr_write(12'h342, 32'hFFFF_FFFF);
        chk("mask_mcause", csr_rdata, 32'h7FFF_FFFF);
        csr_write(12'h7C0, 32'h1234_5678);
        chk("unmapped_read", csr_rdata, 32'd0);

        // Async reset mid-DRAIN
        inflight_empty = 1'b0;
        send_req(1'b0, 5'd4, 32'h0000_0600);
        #2 rst = 1'b0;
        #1;
        chk("arst_flush", {31'd0, flush}, 32'd0);
        chk("arst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("arst_target", redirect_target, 32'd0);
        model_reset();
        inflight_empty = 1'b1;
        csr_addr = 12'h305;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("arst_mtvec", csr_rdata, 32'h0000_1000);
        @(negedge clk);
        check_model();

        // Randomized soak
        for (int n = 0; n < 3000; n++) begin
            req_valid      = ($urandom_range(99) < 30);
            req_is_ret     = $urandom_range(1) == 1;
            req_cause      = 5'($urandom);
            req_pc         = $urandom;
`ifdef TRAP_MTVAL_EN
            req_tval       = $urandom;
`endif
            inflight_empty = ($urandom_range(99) < 60);
            redirect_ready = ($urandom_range(99) < 50);
            csr_we         = ($urandom_range(99) < 20);
            case ($urandom_range(5))
                0: csr_addr = 12'h305;
                1: csr_addr = 12'h341;
                2: csr_addr = 12'h342;
                3: csr_addr = 12'h343;
                4: csr_addr = 12'h7C0;
                default: csr_addr = 12'($urandom);
            endcase
            csr_wdata = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
